// File: rtl/ex_agu_arb.sv
// Two-lane arbitrated scaled-index address generator (Rm + (Ri << scale)) with
// condition-code gating, a single-entry valid/ready output register and lane-B starvation guard.
module ex_agu_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValidA,
  input  logic        reqValidB,
  output logic        reqReadyA,
  output logic        reqReadyB,
  input  logic [31:0] regValRmA,
  input  logic [31:0] regValRmB,
  input  logic [31:0] regValRiA,
  input  logic [31:0] regValRiB,
  input  logic [8:0]  idUIxtA,
  input  logic [8:0]  idUIxtB,
  input  logic        srT,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outAddr,
  output logic [8:0]  outIxt,
  output logic        outSrc,
  output logic [3:0]  starveCnt
);

  typedef enum logic [1:0] {
    CC_AL = 2'b00,
    CC_NV = 2'b01,
    CC_CT = 2'b10,
    CC_CF = 2'b11
  } cc_e;

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic        free;
  logic        grant_a;
  logic        grant_b;
  logic        accept;
  logic        gate_pass;
  cc_e         cc;
  logic [31:0] sel_rm;
  logic [31:0] sel_ri;
  logic [8:0]  sel_ixt;
  logic [31:0] addr;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    free      = !outValid || outReady;
    grant_b   = reqValidB && (!reqValidA || (starveCnt == STARVE_LIMIT));
    grant_a   = reqValidA && !grant_b;
    // Readies stay low while reset is asserted so nothing is consumed and lost.
    reqReadyA = grant_a && free && !reset;
    reqReadyB = grant_b && free && !reset;
    accept    = (grant_a || grant_b) && free;

    sel_rm    = grant_b ? regValRmB : regValRmA;
    sel_ri    = grant_b ? regValRiB : regValRiA;
    sel_ixt   = grant_b ? idUIxtB   : idUIxtA;

    cc        = cc_e'(sel_ixt[7:6]);
    gate_pass = 1'b0;
    unique case (cc)
      CC_AL: gate_pass = 1'b1;
      CC_NV: gate_pass = 1'b0;
      CC_CT: gate_pass = srT;
      CC_CF: gate_pass = !srT;
    endcase

    // Shifted-out Ri bits and the carry out of bit 31 are simply discarded.
    addr = sel_rm + (sel_ri << sel_ixt[1:0]);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the data registers are reset too, because their reset value is observable.
      outValid  <= 1'b0;
      outAddr   <= '0;
      outIxt    <= '0;
      outSrc    <= 1'b0;
      starveCnt <= '0;
    end else if (free) begin
      if (accept && gate_pass) begin
        outValid <= 1'b1;
        outAddr  <= addr;
        outIxt   <= sel_ixt;
        outSrc   <= grant_b;
      end else begin
        outValid <= 1'b0;
      end

      // A gate-failed request still counts as a grant for fairness.
      if (grant_b || !reqValidB) begin
        starveCnt <= '0;
      end else if (grant_a && (starveCnt != STARVE_LIMIT)) begin
        starveCnt <= starveCnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ex_agu_arb.sv
// Self-checking bench for ex_agu_arb: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of arbitration, gating and the output slot.
module tb_ex_agu_arb;

  localparam int STARVE_MAX = 4;

  logic        clock;
  logic        reset;
  logic        reqValidA, reqValidB;
  logic        reqReadyA, reqReadyB;
  logic [31:0] regValRmA, regValRmB, regValRiA, regValRiB;
  logic [8:0]  idUIxtA, idUIxtB;
  logic        srT;
  logic        outValid;
  logic        outReady;
  logic [31:0] outAddr;
  logic [8:0]  outIxt;
  logic        outSrc;
  logic [3:0]  starveCnt;

  ex_agu_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .clock     (clock),
    .reset     (reset),
    .reqValidA (reqValidA),
    .reqValidB (reqValidB),
    .reqReadyA (reqReadyA),
    .reqReadyB (reqReadyB),
    .regValRmA (regValRmA),
    .regValRmB (regValRmB),
    .regValRiA (regValRiA),
    .regValRiB (regValRiB),
    .idUIxtA   (idUIxtA),
    .idUIxtB   (idUIxtB),
    .srT       (srT),
    .outValid  (outValid),
    .outReady  (outReady),
    .outAddr   (outAddr),
    .outIxt    (outIxt),
    .outSrc    (outSrc),
    .starveCnt (starveCnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_addr;
  logic [8:0]  m_ixt;
  bit          m_src;
  int          m_cnt;

  // Per-cycle observations exposed to directed checks
  logic        obs_ra, obs_rb;
  logic [3:0]  cnt_before;
  bit          acc_a, acc_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] agu(input logic [31:0] rm, input logic [31:0] ri,
                                      input logic [1:0] sc);
    longint unsigned b, i, s;
    b = rm;
    i = ri;
    s = (b + (i << sc)) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  function automatic bit cc_pass(input logic [1:0] cc, input logic t);
    case (cc)
      2'd0:    return 1'b1;
      2'd1:    return 1'b0;
      2'd2:    return t == 1'b1;
      default: return t == 1'b0;
    endcase
  endfunction

  // One clock: drive, compare combinational and registered outputs, advance model.
  task automatic cycle(input logic rst, input logic va, input logic vb,
                       input logic [31:0] rma, input logic [31:0] ria,
                       input logic [31:0] rmb, input logic [31:0] rib,
                       input logic [8:0] xa, input logic [8:0] xb,
                       input logic t, input logic ordy);
    bit free, ga, gb, ea, eb;
    logic [8:0]  wx;
    logic [31:0] wrm, wri;
    reset = rst; reqValidA = va; reqValidB = vb;
    regValRmA = rma; regValRiA = ria; regValRmB = rmb; regValRiB = rib;
    idUIxtA = xa; idUIxtB = xb; srT = t; outReady = ordy;
    #1;
    free = !m_valid || ordy;
    gb   = vb && (!va || m_cnt == STARVE_MAX);
    ga   = va && !gb;
    ea   = !rst && ga && free;
    eb   = !rst && gb && free;
    check("readyA",    32'(reqReadyA), 32'(ea));
    check("readyB",    32'(reqReadyB), 32'(eb));
    check("outValid",  32'(outValid),  32'(m_valid));
    check("outAddr",   outAddr,        m_addr);
    check("outIxt",    32'(outIxt),    32'(m_ixt));
    check("outSrc",    32'(outSrc),    32'(m_src));
    check("starveCnt", 32'(starveCnt), 32'(m_cnt));
    obs_ra = reqReadyA; obs_rb = reqReadyB; cnt_before = starveCnt;
    acc_a = ea; acc_b = eb;
    @(posedge clock);
    if (rst) begin
      m_valid = 0; m_addr = '0; m_ixt = '0; m_src = 0; m_cnt = 0;
    end else if (free) begin
      wx  = gb ? xb  : xa;
      wrm = gb ? rmb : rma;
      wri = gb ? rib : ria;
      if ((ga || gb) && cc_pass(wx[7:6], t)) begin
        m_valid = 1; m_addr = agu(wrm, wri, wx[1:0]); m_ixt = wx; m_src = gb;
      end else begin
        m_valid = 0;
      end
      if (gb || !vb)   m_cnt = 0;
      else if (ga)     m_cnt = (m_cnt + 1 > STARVE_MAX) ? STARVE_MAX : m_cnt + 1;
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0, ordy);
  endtask

  task automatic req_a(input logic [31:0] rm, input logic [31:0] ri, input logic [8:0] x,
                       input logic t);
    cycle(1'b0, 1'b1, 1'b0, rm, ri, '0, '0, x, '0, t, 1'b1);
  endtask

  initial begin
    logic [31:0] held_addr;
    logic [3:0]  held_cnt;
    bit          pa, pb;
    logic [31:0] rma, ria, rmb, rib;
    logic [8:0]  xa, xb;

    m_valid = 0; m_addr = '0; m_ixt = '0; m_src = 0; m_cnt = 0;
    // Reset: the model starts from the specified reset values
    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h5, 32'h5, 32'h6, 32'h6, '0, '0, 1'b0, 1'b1);
    check("reset_readyA", 32'(obs_ra), 32'd0);
    check("reset_outValid", 32'(outValid), 32'd0);
    idle(1'b1);

    // Single AL request on lane A, scale x4
    req_a(32'h1000, 32'h10, 9'h002, 1'b0);
    check("al_accepted", 32'(obs_ra), 32'd1);
    check("al_valid", 32'(outValid), 32'd1);
    check("al_addr", outAddr, 32'h1040);
    check("al_src", 32'(outSrc), 32'd0);

    // Wrap: shifted-out Ri bits and carry dropped
    req_a(32'hFFFF_FFF0, 32'h8000_0003, 9'h003, 1'b0);
    check("wrap_addr", outAddr, 32'h0000_0008);
    idle(1'b1);

    // Starvation: both lanes continuously valid
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 32'h100 + 32'(i), 32'h1, 32'h200 + 32'(i), 32'h2,
            9'h000, 9'h001, 1'b0, 1'b1);
      check("starve_cnt", 32'(cnt_before), 32'(i % 5));
      check("starve_grantB", 32'(obs_rb), 32'((i % 5) == 4));
      check("starve_src", 32'(outSrc), 32'((i % 5) == 4));
    end
    idle(1'b1);

    // Back-pressure: load one result, then stall for 3 cycles
    req_a(32'h3000, 32'h4, 9'h001, 1'b0);
    held_addr = outAddr;
    check("bp_loaded", held_addr, 32'h3008);
    held_cnt = starveCnt;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 32'h4000, 32'h1, 32'h5000, 32'h1, 9'h000, 9'h000, 1'b0, 1'b0);
      check("bp_readyA", 32'(obs_ra), 32'd0);
      check("bp_readyB", 32'(obs_rb), 32'd0);
      check("bp_addr", outAddr, held_addr);
      check("bp_cnt", 32'(starveCnt), 32'(held_cnt));
      check("bp_valid", 32'(outValid), 32'd1);
    end
    // Release: drain and refill in the same cycle
    cycle(1'b0, 1'b1, 1'b1, 32'h4000, 32'h1, 32'h5000, 32'h1, 9'h000, 9'h000, 1'b0, 1'b1);
    check("bp_release_ready", 32'(obs_ra), 32'd1);
    check("bp_refill_valid", 32'(outValid), 32'd1);
    check("bp_refill_addr", outAddr, 32'h4001);
    idle(1'b1);

    // Condition-code gating on lane A
    req_a(32'h10, 32'h1, 9'h000, 1'b0);
    req_a(32'h20, 32'h1, 9'h040, 1'b0);
    check("nv_accepted", 32'(obs_ra), 32'd1);
    check("nv_dropped", 32'(outValid), 32'd0);
    req_a(32'h30, 32'h1, 9'h080, 1'b0);
    check("ct0_dropped", 32'(outValid), 32'd0);
    req_a(32'h4, 32'h1, 9'h080, 1'b1);
    check("ct1_valid", 32'(outValid), 32'd1);
    check("ct1_addr", outAddr, 32'h5);
    req_a(32'h8, 32'h2, 9'h0C1, 1'b0);
    check("cf0_valid", 32'(outValid), 32'd1);
    check("cf0_addr", outAddr, 32'hC);
    check("cf0_ixt", 32'(outIxt), 32'h0C1);

    // Reset mid-operation with a held result and starveCnt = 3
    idle(1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 1'b1, 32'h700, 32'(i), 32'h800, 32'h0, 9'h000, 9'h000, 1'b0, 1'b1);
    check("pre_reset_valid", 32'(outValid), 32'd1);
    check("pre_reset_cnt", 32'(starveCnt), 32'd3);
    cycle(1'b1, 1'b1, 1'b1, 32'h700, 32'h9, 32'h800, 32'h0, 9'h000, 9'h000, 1'b0, 1'b0);
    check("reset_no_accept", 32'(obs_ra | obs_rb), 32'd0);
    check("post_reset_valid", 32'(outValid), 32'd0);
    check("post_reset_addr", outAddr, 32'h0);
    check("post_reset_cnt", 32'(starveCnt), 32'd0);
    idle(1'b1);
    check("no_replay", 32'(outValid), 32'd0);

    // Randomized traffic; requesters hold payload until accepted
    pa = 0; pb = 0;
    rma = '0; ria = '0; rmb = '0; rib = '0; xa = '0; xb = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pa && ($urandom_range(0, 3) != 0)) begin
        pa = 1; rma = $urandom; ria = $urandom; xa = 9'($urandom);
      end
      if (!pb && ($urandom_range(0, 1) != 0)) begin
        pb = 1; rmb = $urandom; rib = $urandom; xb = 9'($urandom);
      end
      cycle(1'b0, pa, pb, rma, ria, rmb, rib, xa, xb, 1'($urandom),
            1'($urandom_range(0, 3) != 0));
      if (acc_a) pa = 0;
      if (acc_b) pb = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_agu_arb.md
# ex_agu_arb

Arbitrated, registered front-end that shares one scaled-index address adder (Rm + (Ri << scale)) between two requesters: lane A (main memory-op pipeline) and lane B (secondary agent, e.g. page walker or block-copy engine). It applies the condition-code gate from the index-extension field, computes the 32-bit address and presents it through a single-entry valid/ready output register to the L1 request stage. Lane A has fixed priority, and a starvation counter guarantees lane B forward progress.

## Interface
- STARVE_MAX, 4: consecutive lane-A grants allowed while lane B is waiting before lane B is forced ahead (1..15).
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- reqValidA / reqValidB  in  1  request present on lane A / B.
- reqReadyA / reqReadyB  out  1  lane accepted this cycle when valid & ready.
- regValRmA / regValRmB  in  32  base value.
- regValRiA / regValRiB  in  32  index value.
- idUIxtA / idUIxtB  in  9  [7:6] CC (00 AL, 01 NV, 10 CT, 11 CF), [5:4] type, [2] zext, [1:0] scale (x1/x2/x4/x8).
- srT  in  1  current T predicate, used for CT/CF gating.
- outValid  out  1  output register holds a result.
- outReady  in  1  downstream consumes when outValid & outReady.
- outAddr  out  32  computed address.
- outIxt  out  9  idUIxt of the winning request, passed through.
- outSrc  out  1  0 = lane A, 1 = lane B.
- starveCnt  out  4  current starvation count, for debug/verification.

## Operation
- Address: outAddr = (Rm + (Ri << idUIxt[1:0])) mod 2^32. Shifted-out high bits of Ri are discarded, and the carry out of bit 31 is discarded. Bits [5:4] and [2] do not affect the address; they only pass through on outIxt.
- Slot free: free = !outValid | outReady.
- Grant:
  - grantB = reqValidB & (!reqValidA | (starveCnt == STARVE_MAX)).
  - grantA = reqValidA & !grantB.
- Ready: reqReadyA = grantA & free; reqReadyB = grantB & free. Each ready is a combinational function of the valids, starveCnt and outReady.
- Condition gate for the accepted request:
  - AL (00) passes.
  - NV (01) fails.
  - CT (10) passes when srT = 1.
  - CF (11) passes when srT = 0.
- Failed-gate requests are still accepted (ready asserted, request consumed), but they load nothing. outValid falls if the slot was draining, and no address is emitted.
- Output register, on a clock edge with free:
  - A passing request loads outAddr, outIxt and outSrc and sets outValid = 1.
  - If there is no accept, or the accepted request fails its gate, outValid = 0 and the data registers hold their values.
- Output register, on a clock edge without free: all output registers hold and no accept occurs.
- Starvation counter, updated only on clock edges with free:
  - If lane A is accepted while reqValidB = 1, starveCnt increments, saturating at STARVE_MAX.
  - If lane B is accepted, or reqValidB = 0, starveCnt clears to 0.
  - Otherwise starveCnt holds.
- Gate failure does not change counter accounting: a consumed NV request counts as a grant.

## Timing
- Reset values: outValid 0, outAddr 0, outIxt 0, outSrc 0, starveCnt 0. reqReady* is 0 during reset.
- Reset mid-operation: any held output is dropped and is not replayed.
- Latency is 1 cycle. A request accepted at edge N appears on outAddr/outValid after edge N. Sustained throughput is 1 request per cycle while outReady = 1.
- Back-pressure: while outValid & !outReady, both readies are 0 and outAddr, outIxt and outSrc are stable.
- The same-cycle drain-and-refill case (outValid & outReady with a new accept) loads the new result with no bubble.
- Requesters must hold valid and all payload fields stable until accepted.
- srT is sampled in the accept cycle.

## Test plan
- Single AL request on lane A: Rm=0x1000, Ri=0x10, scale=2, outReady=1 -> outValid high the next cycle, outAddr=0x1040, outSrc=0.
- Wrap case: Rm=0xFFFFFFF0, Ri=0x80000003, scale=3 -> outAddr=0x00000008.
- Starvation with STARVE_MAX=4: both lanes continuously valid, outReady=1 -> grant order A,A,A,A,B,A,A,A,A,B. starveCnt reads 0,1,2,3,4,0,...
- Back-pressure: hold outReady=0 for 3 cycles with outValid=1 -> both readies 0, outAddr unchanged, starveCnt unchanged. On release, the next result follows with no bubble.
- Condition gating, each request on lane A:
  - NV request -> accepted, outValid=0 the next cycle.
  - CT with srT=0 -> dropped.
  - CT with srT=1, Rm=4, Ri=1, scale=0 -> outAddr=5.
  - CF with srT=0 -> passes.
- Reset asserted while outValid=1 and starveCnt=3 -> the next cycle shows outValid=0, outAddr=0 and starveCnt=0, and no output handshake occurs.
